sprite_line_buffer: RTL
=======================

SPRITE_LINE_BUFFER -- requirements
Module: sprite_line_buffer

Interface
REQ-001 Parameter N_SPR, default 5, SHALL set the number of sprite slots; its value matches the upstream load_en width.
REQ-002 Parameter SPRITE_W, default 16, SHALL set the pixels per sprite row, with 1 bpp and MSB leftmost.
REQ-003 clk  input  1: SHALL be the clock, rising edge.
REQ-004 rst  input  1: SHALL be the reset, synchronous, active-high.
REQ-005 load_en  input  N_SPR: one-hot strobe; bit i SHALL mean rom_data is sprite i's row for the next line.
REQ-006 rom_data  input  SPRITE_W: SHALL carry the sprite ROM row data, aligned with load_en.
REQ-007 img_load_done  input  1: single-cycle pulse; SHALL mean all sprite rows have been delivered.
REQ-008 hcount  input  10: SHALL carry the current pixel column.
REQ-009 sprite_x  input  N_SPR*10: SHALL carry the left X position of each sprite, slot i at bits [10i+9:10i].
REQ-010 sprite_color  input  N_SPR*8: SHALL carry the 8-bit colour of each sprite.
REQ-011 pix_valid  output  1: SHALL be high when a sprite pixel is opaque at the registered column.
REQ-012 pix_color  output  8: SHALL carry the colour of the winning sprite.
REQ-013 pix_sprite_id  output  3: SHALL carry the index of the winning sprite.
REQ-014 line_ready  output  1: SHALL be high when the active buffer holds a committed line.
REQ-015 load_err  output  1: SHALL pulse for one cycle on a protocol violation.
REQ-016 collision  output  1: SHALL be high when two or more sprites are opaque at the same pixel.
REQ-017 collision_mask  output  N_SPR: SHALL hold the sprites involved in any collision since the last commit.

Function
REQ-018 Buffering: shadow[i] SHALL be loaded with rom_data on any edge where load_en[i]=1; if several load_en bits are set, each set slot SHALL load the same data.
REQ-019 FSM: states IDLE and LOADING, with a 3-bit load counter that saturates at N_SPR.
- IDLE -> LOADING on any load_en, counter set to 1.
- In LOADING, counter +1 per cycle with load_en set.
REQ-020 Commit: img_load_done in LOADING with counter==N_SPR SHALL copy all shadow to active, set line_ready, and return to IDLE.
REQ-021 Incomplete load: img_load_done in LOADING with counter<N_SPR SHALL skip the commit, pulse load_err, return to IDLE and keep the active buffer unchanged.
REQ-022 Spurious done: img_load_done in IDLE SHALL pulse load_err and cause no commit.
REQ-023 Overflow: a load_en while counter==N_SPR SHALL pulse load_err and still load shadow.
REQ-024 Same-edge load and commit: active SHALL receive the pre-edge shadow value, and shadow SHALL take the new data.
REQ-025 Hit test: off_i = hcount - x_i in 10-bit unsigned arithmetic; sprite i is opaque when hcount>=x_i, off_i<SPRITE_W and active[i][SPRITE_W-1-off_i]=1.
- No wrap-around: a sprite with x_i>1024-SPRITE_W SHALL be clipped at column 1023.
REQ-026 Priority: the lowest index SHALL win among opaque sprites.
REQ-027 Latency: outputs SHALL be registered, one cycle after hcount; pix_valid SHALL be 0 when line_ready=0.
REQ-028 Line persistence: the active buffer SHALL persist across lines until the next successful commit.

Reset
REQ-029 rst SHALL force FSM=IDLE, counter=0, shadow=0, active=0 and all outputs 0, including when asserted mid-LOADING.
REQ-030 After rst, line_ready SHALL stay 0 until the first successful commit.

Configuration
REQ-031 Macro SPRITE_COLLISION_EN defined: collision SHALL be registered, aligned with pix_valid.
- collision_mask SHALL OR in the opaque set on each collision.
- collision_mask SHALL clear on commit.
REQ-032 Macro SPRITE_COLLISION_EN undefined: the collision and collision_mask ports SHALL remain and be tied to 0, with no collision logic.

Structure
REQ-033 Shared package sprite_pkg SHALL hold N_SPR, SPRITE_W, the FSM state encoding and the colour width constant.
REQ-034 Sub-module sprite_hit_unit SHALL hold the per-slot offset compare and bit select, instantiated N_SPR times.

Verification
REQ-035 The bench SHALL cover these directed scenarios:
- Loads 0xFFFF..0x0001 on slots 0-4, then done -> line_ready=1 one cycle later, load_err=0.
- sprite_x0=100, row 0x8001 -> pix_valid at hcount 100 and 115 only, each seen one cycle later; no pixel at 99 or 116.
- Slots 0 and 2 at x=50, both 0xFFFF, SPRITE_COLLISION_EN set -> pix_sprite_id=0, collision=1, collision_mask=5'b00101.
- 3 loads, then done -> load_err pulse, active unchanged, line_ready stays at its prior value.
- sprite_x=1020, row 0xFFFF -> columns 1020-1023 opaque, column 0 not opaque.
- rst during LOADING after 2 loads, then 5 loads and done -> commits cleanly, all outputs 0 during reset.

Source files
------------

// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared sizes, colour width and load FSM encoding for the sprite line buffer
package sprite_pkg;

  localparam int N_SPR    = 5;
  localparam int SPRITE_W = 16;
  localparam int COLOR_W  = 8;
  localparam int X_W      = 10;
  localparam int ID_W     = 3;
  localparam int CNT_W    = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_LOADING = 1'b1
  } load_state_t;

endpackage

// File: rtl/sprite_line_buffer_if.sv
// rtl/sprite_line_buffer_if.sv - sprite ROM row delivery bus (per-slot load strobe, row data, done pulse)
interface sprite_line_buffer_if #(
  parameter int N_SPR    = sprite_pkg::N_SPR,
  parameter int SPRITE_W = sprite_pkg::SPRITE_W
) ();

  logic [N_SPR-1:0]    load_en;
  logic [SPRITE_W-1:0] rom_data;
  logic                img_load_done;

  modport master (
    output load_en,
    output rom_data,
    output img_load_done
  );

  modport slave (
    input load_en,
    input rom_data,
    input img_load_done
  );

endinterface

// File: rtl/sprite_hit_unit.sv
// rtl/sprite_hit_unit.sv - per-slot opacity test: column offset against sprite X, then row bit select
module sprite_hit_unit #(
  parameter int SPRITE_W = sprite_pkg::SPRITE_W
) (
  input  logic [sprite_pkg::X_W-1:0] hcount,
  input  logic [sprite_pkg::X_W-1:0] x,
  input  logic [SPRITE_W-1:0]        row,
  output logic                       opaque
);
  import sprite_pkg::*;

  localparam int IDX_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

  logic [X_W-1:0]   off;
  logic [IDX_W-1:0] idx;
  logic             in_span;

  assign off = hcount - x;
  // hcount >= x keeps the subtraction from wrapping, so sprites near the right edge clip at 1023
  assign in_span = (hcount >= x) && (off < X_W'(SPRITE_W));
  assign idx     = IDX_W'(SPRITE_W - 1) - off[IDX_W-1:0];
  assign opaque  = in_span & row[idx];

endmodule

// File: rtl/sprite_line_buffer.sv
// rtl/sprite_line_buffer.sv - double-buffered sprite row store with per-pixel hit/priority; SPRITE_COLLISION_EN adds collision detect
module sprite_line_buffer #(
  parameter int N_SPR    = sprite_pkg::N_SPR,
  parameter int SPRITE_W = sprite_pkg::SPRITE_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  sprite_line_buffer_if.slave                   ld,
  input  logic [sprite_pkg::X_W-1:0]            hcount,
  input  logic [N_SPR*sprite_pkg::X_W-1:0]      sprite_x,
  input  logic [N_SPR*sprite_pkg::COLOR_W-1:0]  sprite_color,
  output logic                                  pix_valid,
  output logic [sprite_pkg::COLOR_W-1:0]        pix_color,
  output logic [sprite_pkg::ID_W-1:0]           pix_sprite_id,
  output logic                                  line_ready,
  output logic                                  load_err,
  output logic                                  collision,
  output logic [N_SPR-1:0]                      collision_mask
);
  import sprite_pkg::*;

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(N_SPR);

  load_state_t              state, state_nx;
  logic [CNT_W-1:0]         cnt, cnt_nx;
  logic                     commit, err_nx;
  logic [N_SPR-1:0][SPRITE_W-1:0] shadow, active;
  logic [N_SPR-1:0]         opaque;
  logic [ID_W-1:0]          win_id;
  logic [COLOR_W-1:0]       win_color;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        if (|ld.load_en) begin
          state_nx = ST_LOADING;
          cnt_nx   = CNT_W'(1);
        end
      end
      ST_LOADING: begin
        if (ld.img_load_done) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if ((|ld.load_en) && (cnt != CNT_FULL)) begin
          cnt_nx = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // A done arriving with a load on the same edge is a legal commit, not an overflow
  always_comb begin
    commit = 1'b0;
    err_nx = 1'b0;
    case (state)
      ST_IDLE: err_nx = ld.img_load_done;
      ST_LOADING: begin
        if (ld.img_load_done) begin
          if (cnt == CNT_FULL) commit = 1'b1;
          else                 err_nx = 1'b1;
        end else if ((|ld.load_en) && (cnt == CNT_FULL)) begin
          err_nx = 1'b1;
        end
      end
      default: err_nx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow     <= '0;
      active     <= '0;
      line_ready <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      for (int i = 0; i < N_SPR; i++) begin
        if (ld.load_en[i]) shadow[i] <= ld.rom_data;
      end
      if (commit) begin
        active     <= shadow;
        line_ready <= 1'b1;
      end
      load_err <= err_nx;
    end
  end

  for (genvar g = 0; g < N_SPR; g++) begin : g_hit
    sprite_hit_unit #(.SPRITE_W(SPRITE_W)) u_hit (
      .hcount (hcount),
      .x      (sprite_x[X_W*g +: X_W]),
      .row    (active[g]),
      .opaque (opaque[g])
    );
  end

  // Walk from the highest slot down so the lowest opaque index is what remains
  always_comb begin
    win_id    = '0;
    win_color = '0;
    for (int i = N_SPR - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        win_id    = ID_W'(i);
        win_color = sprite_color[COLOR_W*i +: COLOR_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid     <= 1'b0;
      pix_color     <= '0;
      pix_sprite_id <= '0;
    end else begin
      pix_valid     <= line_ready && (|opaque);
      pix_color     <= line_ready ? win_color : '0;
      pix_sprite_id <= line_ready ? win_id : '0;
    end
  end

`ifdef SPRITE_COLLISION_EN
  localparam logic [N_SPR-1:0] ONE = N_SPR'(1);

  logic multi_hit;
  assign multi_hit = line_ready && ((opaque & (opaque - ONE)) != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      collision      <= 1'b0;
      collision_mask <= '0;
    end else begin
      collision <= multi_hit;
      if (commit)         collision_mask <= '0;
      else if (multi_hit) collision_mask <= collision_mask | opaque;
    end
  end
`else
  assign collision      = 1'b0;
  assign collision_mask = '0;
`endif

endmodule
